sync_fifo_hs: RTL

//  Parametrised synchronous FIFO with valid/ready handshakes on both sides.

---
 rtl/sync_fifo_pkg.sv | 11 +
 rtl/sync_fifo_hs_if.sv | 24 ++
 rtl/sync_fifo_out_stage.sv | 43 ++++
 rtl/sync_fifo_hs.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the valid/ready handshake FIFO.
package sync_fifo_pkg;

    localparam string OUT_REG_TRUE = "TRUE";

    // Occupancy counter width: must hold DEPTH, or DEPTH+1 when the output register is present.
    function automatic int unsigned cnt_w(input int unsigned depth, input bit out_reg);
        return $clog2(depth + 32'(out_reg) + 32'd1);
    endfunction

endpackage

// File: rtl/sync_fifo_hs_if.sv
// Write-side and read-side valid/ready handshake bundle for sync_fifo_hs.
interface sync_fifo_hs_if #(
    parameter int unsigned DATA_WIDTH = 8
);

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    // slave: the FIFO itself; master: the surrounding producer/consumer pair.
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

endinterface

// File: rtl/sync_fifo_out_stage.sv
// Registered read port: holds the FIFO head, bypasses writes into an empty FIFO,
// and refills from the memory head whenever the register empties or is consumed.
module sync_fifo_out_stage #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  fifo_clk,
    input  logic                  fifo_rst,
    input  logic                  flush,
    input  logic                  wr_fire,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  mem_empty,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  bypass_c,
    output logic                  pop_c
);

    logic take_c;

    // The register can take a new beat when it is empty or its beat is leaving this cycle.
    assign take_c   = !m_valid || m_ready;
    assign bypass_c = take_c && mem_empty && wr_fire;
    assign pop_c    = take_c && !mem_empty;

    always_ff @(posedge fifo_clk or posedge fifo_rst) begin
        if (fifo_rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (take_c) begin
            m_valid <= bypass_c || pop_c;
            if (pop_c) begin
                m_data <= mem_rdata;
            end else if (bypass_c) begin
                m_data <= wr_data;
            end
        end
    end

endmodule

// File: rtl/sync_fifo_hs.sv
// Single-clock FIFO with valid/ready on both sides, optional output register,
// almost-full/empty thresholds, synchronous flush and a peak-occupancy watermark.
module sync_fifo_hs
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AWIDTH     = $clog2(DEPTH),
    parameter string       OUT_REG    = "TRUE"
) (
    input  logic              fifo_clk,
    input  logic              fifo_rst,
    input  logic              fifo_flush,
    sync_fifo_hs_if.slave     bus,
    input  logic [AWIDTH:0]   afull_thresh,
    input  logic [AWIDTH:0]   aempty_thresh,
    output logic              fifo_almost_full,
    output logic              fifo_almost_empty,
    output logic [AWIDTH:0]   fifo_count,
    input  logic              wm_clr,
    output logic [AWIDTH:0]   fifo_peak
);

    localparam bit          HAS_OREG = (OUT_REG == OUT_REG_TRUE);
    localparam int unsigned PW       = AWIDTH + 1;
    localparam int unsigned CW       = cnt_w(DEPTH, HAS_OREG);
    localparam int unsigned CAP      = DEPTH + (HAS_OREG ? 32'd1 : 32'd0);
    localparam logic [CW-1:0] CAP_CNT = CW'(CAP);

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic [CW-1:0]         peak;
    logic [CW-1:0]         peak_nxt;
    logic                  s_ready_q;

    logic                  wr_fire_c;
    logic                  rd_fire_c;
    logic                  mem_empty_c;
    logic                  mem_wr_c;
    logic                  mem_rd_c;
    logic [DATA_WIDTH-1:0] mem_rdata_c;

    assign wr_fire_c   = bus.s_valid && s_ready_q;
    assign rd_fire_c   = bus.m_valid && bus.m_ready;
    assign mem_empty_c = (wptr == rptr);
    assign mem_rdata_c = mem[rptr[AWIDTH-1:0]];

    // Read port: registered head with bypass, or the memory head read directly.
    if (HAS_OREG) begin : g_oreg
        logic bypass_c;
        logic pop_c;

        sync_fifo_out_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_out_stage (
            .fifo_clk  (fifo_clk),
            .fifo_rst  (fifo_rst),
            .flush     (fifo_flush),
            .wr_fire   (wr_fire_c),
            .wr_data   (bus.s_data),
            .mem_empty (mem_empty_c),
            .mem_rdata (mem_rdata_c),
            .m_ready   (bus.m_ready),
            .m_valid   (bus.m_valid),
            .m_data    (bus.m_data),
            .bypass_c  (bypass_c),
            .pop_c     (pop_c)
        );

        assign mem_wr_c = wr_fire_c && !bypass_c && !fifo_flush;
        assign mem_rd_c = pop_c && !fifo_flush;
    end else begin : g_noreg
        logic m_valid_q;

        always_ff @(posedge fifo_clk or posedge fifo_rst) begin
            if (fifo_rst) begin
                m_valid_q <= 1'b0;
            end else begin
                m_valid_q <= (count_nxt != '0);
            end
        end

        assign bus.m_valid = m_valid_q;
        assign bus.m_data  = mem_rdata_c;
        assign mem_wr_c    = wr_fire_c && !fifo_flush;
        assign mem_rd_c    = rd_fire_c && !fifo_flush;
    end

    // Occupancy and watermark; flush drops every beat but leaves the watermark alone.
    always_comb begin
        count_nxt = count;
        peak_nxt  = peak;
        if (fifo_flush) begin
            count_nxt = '0;
        end else if (wr_fire_c && !rd_fire_c) begin
            count_nxt = count + CW'(1);
        end else if (!wr_fire_c && rd_fire_c) begin
            count_nxt = count - CW'(1);
        end
        if (wm_clr) begin
            peak_nxt = count_nxt;
        end else if (count_nxt > peak) begin
            peak_nxt = count_nxt;
        end
    end

    always_ff @(posedge fifo_clk or posedge fifo_rst) begin
        if (fifo_rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            peak      <= '0;
            s_ready_q <= 1'b1;
        end else begin
            if (fifo_flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (mem_wr_c) begin
                    wptr <= wptr + PW'(1);
                end
                if (mem_rd_c) begin
                    rptr <= rptr + PW'(1);
                end
            end
            count     <= count_nxt;
            peak      <= peak_nxt;
            s_ready_q <= (count_nxt != CAP_CNT);
        end
    end

    // Storage array carries no reset; only the pointers define what is valid.
    always_ff @(posedge fifo_clk) begin
        if (mem_wr_c) begin
            mem[wptr[AWIDTH-1:0]] <= bus.s_data;
        end
    end

    assign bus.s_ready       = s_ready_q;
    assign fifo_count        = count;
    assign fifo_peak         = peak;
    assign fifo_almost_full  = (count >= afull_thresh);
    assign fifo_almost_empty = (count <= aempty_thresh);

    a_no_write_when_full : assert property (
        @(posedge fifo_clk) disable iff (fifo_rst) (count == CAP_CNT) |-> !wr_fire_c
    );

    a_hold_while_stalled : assert property (
        @(posedge fifo_clk) disable iff (fifo_rst || fifo_flush)
        (bus.m_valid && !bus.m_ready) |=> (bus.m_valid && $stable(bus.m_data))
    );

endmodule
